// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per cycle from a
// combinational instruction memory and buffers {instr, pc} in an in-order queue.
module fetch_unit #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fetch_en,
    output logic [XLEN-1:0]           imem_addr,
    input  logic [31:0]               imem_instr,
    input  logic                      redirect_valid,
    input  logic [XLEN-1:0]           redirect_pc,
    output logic                      if_valid,
    input  logic                      if_ready,
    output logic [31:0]               if_instr,
    output logic [XLEN-1:0]           if_pc,
    output logic                      misalign_err,
    output logic [$clog2(FQ_DEPTH):0] fq_count
);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0033;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            misalign_q, misalign_d;

    logic [31:0]     instr_mem_q [FQ_DEPTH];
    logic [XLEN-1:0] pc_mem_q    [FQ_DEPTH];

    logic full, deq, enq;

    assign if_valid = (count_q != '0);
    assign full     = (count_q == CW'(FQ_DEPTH));
    assign deq      = if_valid && if_ready;
    // A full queue still accepts a fetch when the head leaves in the same cycle.
    assign enq      = fetch_en && !redirect_valid && (!full || deq);

    always_comb begin
        pc_d       = pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        misalign_d = misalign_q;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
        end else begin
            if (deq) head_d = head_q + PW'(1);
            if (enq) begin
                tail_d = tail_q + PW'(1);
                pc_d   = pc_q + XLEN'(4);
            end
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    // Queue storage is data only; validity is tracked entirely by count_q.
    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem_q[tail_q] <= imem_instr;
            pc_mem_q[tail_q]    <= pc_q;
        end
    end

    assign imem_addr    = pc_q;
    assign if_instr     = if_valid ? instr_mem_q[head_q] : NOP;
    assign if_pc        = if_valid ? pc_mem_q[head_q] : '0;
    assign misalign_err = misalign_q;
    assign fq_count     = count_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (count_q <= CW'(FQ_DEPTH));
            assert (if_valid == (count_q != '0));
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit, checked against a queue-based
// reference model of the fetch stage.
module tb_fetch_unit;
    localparam int          DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h0;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        fetch_en = 1'b0, redirect_valid = 1'b0, if_ready = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic [63:0] imem_addr, if_pc;
    logic [31:0] imem_instr, if_instr;
    logic        if_valid, misalign_err;
    logic [2:0]  fq_count;

    int checks = 0;
    int errors = 0;

    logic [95:0] mq[$];
    logic [63:0] m_pc;
    logic        m_mis;

    fetch_unit #(.XLEN(64), .RESET_PC(RPC), .FQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(imem_addr),
        .imem_instr(imem_instr), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .misalign_err(misalign_err),
        .fq_count(fq_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [63:0] a);
        case (a)
            64'h00: return 32'h0000_0033;
            64'h04: return 32'h0010_8093;
            64'h08: return 32'h0020_8113;
            64'h0C: return 32'h0020_81b3;
            64'h58: return 32'hA001_A001;
            64'h6C: return 32'hB001_B001;
            default: return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
        endcase
    endfunction

    assign imem_instr = imem(imem_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [31:0] ei;
        logic [63:0] ep;
        ei = (mq.size() != 0) ? mq[0][95:64] : 32'h0000_0033;
        ep = (mq.size() != 0) ? mq[0][63:0]  : 64'h0;
        check("imem_addr", imem_addr, m_pc);
        check("if_valid", 64'(if_valid), 64'(mq.size() != 0));
        check("if_instr", 64'(if_instr), 64'(ei));
        check("if_pc", if_pc, ep);
        check("fq_count", 64'(fq_count), 64'(mq.size()));
        check("misalign_err", 64'(misalign_err), 64'(m_mis));
    endtask

    // One clock: inputs applied after a falling edge, outputs checked at the next one.
    task automatic cycle(input logic fe, input logic rdy, input logic rv, input logic [63:0] rpc);
        logic deq, enq;
        logic [31:0] w;
        fetch_en       = fe;
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        deq = (mq.size() != 0) && rdy;
        enq = fe && !rv && ((mq.size() < DEPTH) || deq);
        w   = imem(m_pc);
        @(posedge clk);
        if (rv) begin
            mq.delete();
            m_pc = {rpc[63:2], 2'b00};
            if (rpc[1:0] != 2'b00) m_mis = 1'b1;
        end else begin
            if (deq) void'(mq.pop_front());
            if (enq) begin
                mq.push_back({w, m_pc});
                m_pc = m_pc + 64'd4;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc  = RPC;
        m_mis = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fetch_en = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
    endtask

    initial begin
        model_reset();
        do_reset();

        // sequential fetch with decode always ready
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, '0);

        // backpressure from reset: fill, stick at full, then drain while fetching
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, '0);
        check("bp_addr_held", imem_addr, 64'h10);
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, '0);

        // redirect after 3 fetches, then misaligned and aligned redirects
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, '0);
        cycle(1, 1, 1, 64'h58);
        cycle(1, 0, 0, '0);
        check("redir_head", 64'(if_instr), 64'hA001_A001);
        cycle(1, 1, 0, '0);
        cycle(1, 0, 1, 64'h6E);
        check("mis_pc", imem_addr, 64'h6C);
        cycle(1, 0, 0, '0);
        check("mis_head", 64'(if_instr), 64'hB001_B001);
        cycle(1, 1, 1, 64'h100);
        cycle(1, 1, 0, '0);
        // PC wrap across 2^64
        cycle(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, '0);

        // fetch_en low: queue drains, PC frozen, then resumes
        do_reset();
        cycle(1, 0, 0, '0);
        cycle(1, 0, 0, '0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, '0);
        check("fe_low_addr", imem_addr, 64'h8);
        cycle(0, 0, 1, 64'h58);
        cycle(1, 1, 0, '0);
        cycle(1, 1, 0, '0);

        // asynchronous reset between clock edges with 3 entries queued
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, '0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(if_valid), 64'h0);
        check("arst_addr", imem_addr, RPC);
        check("arst_count", 64'(fq_count), 64'h0);
        model_reset();
        fetch_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
        cycle(1, 0, 0, '0);
        check("arst_first_pc", if_pc, 64'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic fe, rdy, rv;
            logic [63:0] rpc;
            fe  = ($urandom_range(0, 9) < 8);
            rdy = ($urandom_range(0, 9) < 6);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 255))
                                              : {$urandom, $urandom};
            cycle(fe, rdy, rv, rpc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
